// File: rtl/noc_top.sv
// noc_top: five-port packet switch (mem, pe0, pe1, pe2, adder).
//
// Each input port has a 1-deep buffer. Each output port has a 1-deep
// register. A buffered packet goes to the output whose node address matches
// the destination field. Contention for an output is resolved round-robin,
// in the index order mem, pe0, pe1, pe2, adder. A packet is dropped when its
// destination is not a node address, or when it names its own entry port.
//
// Ports (p in mem, pe0, pe1, pe2, adder):
//   clk, reset_n        single clock; synchronous, active-low reset
//   p_in_valid/ready    input handshake; ready = live && buffer empty
//   p_in_data           packet {sel, dest[2:0], src[2:0], data[39:0]}
//   p_out_valid/ready   output handshake; data and valid hold while stalled
//   p_out_data          delivered packet, bit-for-bit unchanged
//   err_o, err_cnt      drop pulse and saturating drop count; these ports
//                       exist only when NOC_DEST_ERR_EN is defined
// FL and BL are timing annotations only and do not change cycle behaviour.

module noc_top #(
  parameter int WIDTH      = 47,
  parameter int ADDR_WIDTH = 3,
  parameter int FL         = 2,
  parameter int BL         = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mem_in_valid,
  output logic             mem_in_ready,
  input  logic [WIDTH-1:0] mem_in_data,
  output logic             mem_out_valid,
  input  logic             mem_out_ready,
  output logic [WIDTH-1:0] mem_out_data,
  input  logic             pe0_in_valid,
  output logic             pe0_in_ready,
  input  logic [WIDTH-1:0] pe0_in_data,
  output logic             pe0_out_valid,
  input  logic             pe0_out_ready,
  output logic [WIDTH-1:0] pe0_out_data,
  input  logic             pe1_in_valid,
  output logic             pe1_in_ready,
  input  logic [WIDTH-1:0] pe1_in_data,
  output logic             pe1_out_valid,
  input  logic             pe1_out_ready,
  output logic [WIDTH-1:0] pe1_out_data,
  input  logic             pe2_in_valid,
  output logic             pe2_in_ready,
  input  logic [WIDTH-1:0] pe2_in_data,
  output logic             pe2_out_valid,
  input  logic             pe2_out_ready,
  output logic [WIDTH-1:0] pe2_out_data,
  input  logic             adder_in_valid,
  output logic             adder_in_ready,
  input  logic [WIDTH-1:0] adder_in_data,
  output logic             adder_out_valid,
  input  logic             adder_out_ready,
  output logic [WIDTH-1:0] adder_out_data
`ifdef NOC_DEST_ERR_EN
  ,
  output logic             err_o,
  output logic [7:0]       err_cnt
`endif
);

  localparam int unsigned NP       = 5;
  localparam int unsigned DEST_LSB = WIDTH - 1 - ADDR_WIDTH;

  typedef enum logic [2:0] {
    NODE_PE2   = 3'b000,
    NODE_PE1   = 3'b001,
    NODE_PE0   = 3'b011,
    NODE_ADDER = 3'b100,
    NODE_MEM   = 3'b110
  } node_e;

  // Timing annotations are accepted but have no cycle-level meaning.
  if (FL < 0 || BL < 0) begin : g_bad_timing_annotation
  end

  function automatic logic [ADDR_WIDTH-1:0] node_addr(input int unsigned idx);
    case (idx)
      0:       node_addr = ADDR_WIDTH'(NODE_MEM);
      1:       node_addr = ADDR_WIDTH'(NODE_PE0);
      2:       node_addr = ADDR_WIDTH'(NODE_PE1);
      3:       node_addr = ADDR_WIDTH'(NODE_PE2);
      default: node_addr = ADDR_WIDTH'(NODE_ADDER);
    endcase
  endfunction

  function automatic logic dest_known(input logic [ADDR_WIDTH-1:0] d);
    dest_known = 1'b0;
    for (int unsigned k = 0; k < NP; k++) begin
      if (d == node_addr(k)) dest_known = 1'b1;
    end
  endfunction

  logic                  live;
  logic [NP-1:0]         in_valid, in_ready_w, out_ready, out_valid_q;
  logic [NP-1:0]         full, drop, free_w, grant_vld;
  logic [WIDTH-1:0]      in_data    [NP];
  logic [WIDTH-1:0]      in_buf     [NP];
  logic [WIDTH-1:0]      out_data_q [NP];
  logic [ADDR_WIDTH-1:0] dest       [NP];
  logic [NP-1:0]         req        [NP];  // req[output][input]
  logic [2:0]            grant_idx  [NP];
  logic [2:0]            ptr        [NP];

  assign in_valid  = {adder_in_valid, pe2_in_valid, pe1_in_valid, pe0_in_valid, mem_in_valid};
  assign out_ready = {adder_out_ready, pe2_out_ready, pe1_out_ready, pe0_out_ready, mem_out_ready};
  assign in_data[0] = mem_in_data;
  assign in_data[1] = pe0_in_data;
  assign in_data[2] = pe1_in_data;
  assign in_data[3] = pe2_in_data;
  assign in_data[4] = adder_in_data;

  // live keeps in_ready low through reset and raises it one edge after release.
  assign in_ready_w = {NP{live}} & ~full;

  assign {adder_in_ready, pe2_in_ready, pe1_in_ready, pe0_in_ready, mem_in_ready} = in_ready_w;
  assign {adder_out_valid, pe2_out_valid, pe1_out_valid, pe0_out_valid, mem_out_valid} = out_valid_q;
  assign mem_out_data   = out_data_q[0];
  assign pe0_out_data   = out_data_q[1];
  assign pe1_out_data   = out_data_q[2];
  assign pe2_out_data   = out_data_q[3];
  assign adder_out_data = out_data_q[4];

  // Route decode: a self-addressed or unknown destination is a drop, never a request.
  always_comb begin
    drop = '0;
    for (int unsigned o = 0; o < NP; o++) req[o] = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      dest[i] = in_buf[i][DEST_LSB +: ADDR_WIDTH];
      if (full[i]) begin
        if (!dest_known(dest[i]) || dest[i] == node_addr(i)) begin
          drop[i] = 1'b1;
        end else begin
          for (int unsigned o = 0; o < NP; o++) begin
            if (dest[i] == node_addr(o)) req[o][i] = 1'b1;
          end
        end
      end
    end
  end

  // Per-output round-robin search starting at ptr; first requester wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = '0;
    for (int unsigned o = 0; o < NP; o++) begin
      grant_idx[o] = '0;
      for (int unsigned k = 0; k < NP; k++) begin
        idx = (32'(ptr[o]) + k) % NP;
        if ((!out_valid_q[o] || out_ready[o]) && !grant_vld[o] && req[o][idx]) begin
          grant_vld[o] = 1'b1;
          grant_idx[o] = 3'(idx);
        end
      end
    end
  end

  always_comb begin
    free_w = drop;
    for (int unsigned i = 0; i < NP; i++) begin
      for (int unsigned o = 0; o < NP; o++) begin
        if (grant_vld[o] && grant_idx[o] == 3'(i)) free_w[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      live        <= 1'b0;
      full        <= '0;
      out_valid_q <= '0;
      for (int unsigned i = 0; i < NP; i++) begin
        in_buf[i]     <= '0;
        out_data_q[i] <= '0;
        ptr[i]        <= '0;
      end
    end else begin
      live <= 1'b1;
      for (int unsigned i = 0; i < NP; i++) begin
        if (in_valid[i] && in_ready_w[i]) begin
          full[i]   <= 1'b1;
          in_buf[i] <= in_data[i];
        end else if (free_w[i]) begin
          full[i] <= 1'b0;
        end
      end
      for (int unsigned o = 0; o < NP; o++) begin
        if (grant_vld[o]) begin
          out_valid_q[o] <= 1'b1;
          out_data_q[o]  <= in_buf[grant_idx[o]];
          ptr[o]         <= (grant_idx[o] == 3'(NP - 1)) ? '0 : grant_idx[o] + 3'd1;
        end else if (out_ready[o]) begin
          out_valid_q[o] <= 1'b0;
        end
      end
    end
  end

`ifdef NOC_DEST_ERR_EN
  logic [3:0] drop_cnt;
  logic [8:0] cnt_sum;

  always_comb begin
    drop_cnt = '0;
    for (int unsigned i = 0; i < NP; i++) drop_cnt = drop_cnt + 4'(drop[i]);
    cnt_sum = {1'b0, err_cnt} + 9'(drop_cnt);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_o   <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_o   <= |drop;
      err_cnt <= cnt_sum[8] ? '1 : cnt_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_noc_top.sv
module tb_noc_top;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  in_valid, in_ready, out_valid, out_ready;
  logic [46:0] in_data  [5];
  logic [46:0] out_data [5];
`ifdef NOC_DEST_ERR_EN
  logic        err_o;
  logic [7:0]  err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [2:0]  addr [5];
  logic [46:0] pa, pb, pc;
  logic [46:0] rp [5];

  always #5 clk = ~clk;

  noc_top dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_in_valid    (in_valid[0]),
    .mem_in_ready    (in_ready[0]),
    .mem_in_data     (in_data[0]),
    .mem_out_valid   (out_valid[0]),
    .mem_out_ready   (out_ready[0]),
    .mem_out_data    (out_data[0]),
    .pe0_in_valid    (in_valid[1]),
    .pe0_in_ready    (in_ready[1]),
    .pe0_in_data     (in_data[1]),
    .pe0_out_valid   (out_valid[1]),
    .pe0_out_ready   (out_ready[1]),
    .pe0_out_data    (out_data[1]),
    .pe1_in_valid    (in_valid[2]),
    .pe1_in_ready    (in_ready[2]),
    .pe1_in_data     (in_data[2]),
    .pe1_out_valid   (out_valid[2]),
    .pe1_out_ready   (out_ready[2]),
    .pe1_out_data    (out_data[2]),
    .pe2_in_valid    (in_valid[3]),
    .pe2_in_ready    (in_ready[3]),
    .pe2_in_data     (in_data[3]),
    .pe2_out_valid   (out_valid[3]),
    .pe2_out_ready   (out_ready[3]),
    .pe2_out_data    (out_data[3]),
    .adder_in_valid  (in_valid[4]),
    .adder_in_ready  (in_ready[4]),
    .adder_in_data   (in_data[4]),
    .adder_out_valid (out_valid[4]),
    .adder_out_ready (out_ready[4]),
    .adder_out_data  (out_data[4])
`ifdef NOC_DEST_ERR_EN
    ,
    .err_o           (err_o),
    .err_cnt         (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [46:0] mk_pkt(input logic sel, input logic [2:0] d,
                                         input logic [2:0] s, input logic [39:0] data);
    return {sel, d, s, data};
  endfunction

  initial begin
    addr[0] = 3'b110;
    addr[1] = 3'b011;
    addr[2] = 3'b001;
    addr[3] = 3'b000;
    addr[4] = 3'b100;
    reset_n   = 1'b0;
    in_valid  = '0;
    out_ready = '1;
    for (int i = 0; i < 5; i++) in_data[i] = '0;

    // Reset state
    step();
    step();
    check("rst_in_ready", in_ready, 5'h00);
    check("rst_out_valid", out_valid, 5'h00);
    for (int i = 0; i < 5; i++) check($sformatf("rst_out_data_%0d", i), out_data[i], 47'h0);
`ifdef NOC_DEST_ERR_EN
    check("rst_err_o", err_o, 1'b0);
    check("rst_err_cnt", err_cnt, 8'd0);
`endif
    reset_n = 1'b1;
    step();
    check("release_in_ready", in_ready, 5'h1f);

    // Single route mem -> pe0
    pa = 47'h5E_0000000155;
    in_valid[0] = 1'b1;
    in_data[0]  = pa;
    step();
    in_valid[0] = 1'b0;
    check("single_ready_drop", in_ready[0], 1'b0);
    check("single_t1_valid", out_valid, 5'h00);
    step();
    check("single_valid", out_valid, 5'b00010);
    check("single_data", out_data[1], pa);
    check("single_ready_back", in_ready[0], 1'b1);
    step();
    check("single_consumed", out_valid, 5'h00);

    // All 20 legal src/dest pairs
    for (int s = 0; s < 5; s++) begin
      for (int d = 0; d < 5; d++) begin
        if (s != d) begin
          pa = mk_pkt(1'(s + d), addr[d], addr[s], 40'($urandom_range(0, 1023)));
          in_valid[s] = 1'b1;
          in_data[s]  = pa;
          step();
          in_valid[s] = 1'b0;
          step();
          check($sformatf("route_valid_%0d_%0d", s, d), out_valid, 5'b00001 << d);
          check($sformatf("route_data_%0d_%0d", s, d), out_data[d], pa);
          step();
        end
      end
    end

    // Contention: pe0, pe1, pe2 -> adder in the same cycle
    for (int i = 1; i <= 3; i++) begin
      rp[i] = mk_pkt(1'b0, 3'b100, addr[i], 40'(16'hA000 + i));
      in_valid[i] = 1'b1;
      in_data[i]  = rp[i];
    end
    step();
    in_valid = '0;
    check("cont_ready_low", in_ready[3:1], 3'b000);
    step();
    check("cont_first_valid", out_valid, 5'b10000);
    check("cont_first_data", out_data[4], rp[1]);
    check("cont_winner_ready", in_ready[3:1], 3'b001);
    step();
    check("cont_second_data", out_data[4], rp[2]);
    check("cont_second_valid", out_valid, 5'b10000);
    step();
    check("cont_third_data", out_data[4], rp[3]);
    step();
    check("cont_drained", out_valid, 5'h00);

    // Round-robin rotation: after pe1 wins, pe2 outranks pe0
    pa = mk_pkt(1'b1, 3'b100, addr[2], 40'h111);
    in_valid[2] = 1'b1;
    in_data[2]  = pa;
    step();
    in_valid[2] = 1'b0;
    step();
    check("rr_solo_data", out_data[4], pa);
    step();
    pb = mk_pkt(1'b0, 3'b100, addr[1], 40'h222);
    pc = mk_pkt(1'b0, 3'b100, addr[3], 40'h333);
    in_valid[1] = 1'b1;
    in_data[1]  = pb;
    in_valid[3] = 1'b1;
    in_data[3]  = pc;
    step();
    in_valid = '0;
    step();
    check("rr_first_pe2", out_data[4], pc);
    check("rr_loser_held", in_ready[1], 1'b0);
    check("rr_winner_free", in_ready[3], 1'b1);
    step();
    check("rr_second_pe0", out_data[4], pb);
    step();

    // Backpressure: pe1 -> mem with mem_out_ready low
    out_ready[0] = 1'b0;
    pa = mk_pkt(1'b0, 3'b110, 3'b001, 40'hAAAA);
    pb = mk_pkt(1'b1, 3'b110, 3'b001, 40'hBBBB);
    pc = mk_pkt(1'b0, 3'b110, 3'b001, 40'hCCCC);
    in_valid[2] = 1'b1;
    in_data[2]  = pa;
    step();
    in_valid[2] = 1'b0;
    step();
    check("bp_a_valid", out_valid[0], 1'b1);
    check("bp_a_data", out_data[0], pa);
    check("bp_ready_free", in_ready[2], 1'b1);
    in_valid[2] = 1'b1;
    in_data[2]  = pb;
    step();
    // Offer C while not ready; it must be ignored.
    in_data[2] = pc;
    check("bp_b_blocks", in_ready[2], 1'b0);
    check("bp_hold_1", out_data[0], pa);
    step();
    in_valid[2] = 1'b0;
    check("bp_hold_2", out_data[0], pa);
    check("bp_hold_valid", out_valid[0], 1'b1);
    check("bp_still_blocked", in_ready[2], 1'b0);
    step();
    check("bp_hold_3", out_data[0], pa);
    step();
    check("bp_hold_4", out_data[0], pa);
    out_ready[0] = 1'b1;
    step();
    check("bp_b_valid", out_valid[0], 1'b1);
    check("bp_b_data", out_data[0], pb);
    check("bp_ready_back", in_ready[2], 1'b1);
    step();
    check("bp_drained", out_valid, 5'h00);

    // Invalid destination 101 from adder
    in_valid[4] = 1'b1;
    in_data[4]  = mk_pkt(1'b0, 3'b101, 3'b100, 40'h5555);
    step();
    in_valid[4] = 1'b0;
    check("inv_ready_low", in_ready[4], 1'b0);
`ifdef NOC_DEST_ERR_EN
    check("inv_err_pre", err_o, 1'b0);
`endif
    step();
    check("inv_ready_back", in_ready[4], 1'b1);
    check("inv_no_out", out_valid, 5'h00);
`ifdef NOC_DEST_ERR_EN
    check("inv_err_pulse", err_o, 1'b1);
    check("inv_err_cnt", err_cnt, 8'd1);
`endif
    step();
    check("inv_no_out_late", out_valid, 5'h00);
`ifdef NOC_DEST_ERR_EN
    check("inv_err_clear", err_o, 1'b0);
`endif

    // Self-addressed packet from pe0
    in_valid[1] = 1'b1;
    in_data[1]  = mk_pkt(1'b1, 3'b011, 3'b011, 40'h6666);
    step();
    in_valid[1] = 1'b0;
    step();
    check("self_ready_back", in_ready[1], 1'b1);
    check("self_no_out", out_valid, 5'h00);
`ifdef NOC_DEST_ERR_EN
    check("self_err_cnt", err_cnt, 8'd2);
`endif
    step();
    check("self_no_out_late", out_valid, 5'h00);

    // Reset with packets in output registers and an input buffer
    out_ready = '0;
    in_valid  = 5'b00111;
    in_data[0] = mk_pkt(1'b0, 3'b000, 3'b110, 40'h1);
    in_data[1] = mk_pkt(1'b0, 3'b100, 3'b011, 40'h2);
    in_data[2] = mk_pkt(1'b0, 3'b110, 3'b001, 40'h3);
    step();
    in_valid = 5'b01000;
    in_data[3] = mk_pkt(1'b0, 3'b110, 3'b000, 40'h4);
    step();
    in_valid = '0;
    check("flight_valid", out_valid, 5'b11001);
    check("flight_pe2_held", in_ready[3], 1'b0);
    reset_n = 1'b0;
    step();
    check("mid_rst_valid", out_valid, 5'h00);
    check("mid_rst_ready", in_ready, 5'h00);
    check("mid_rst_data", out_data[3], 47'h0);
    reset_n   = 1'b1;
    out_ready = '1;
    step();
    check("post_rst_ready", in_ready, 5'h1f);
    check("post_rst_valid", out_valid, 5'h00);
`ifdef NOC_DEST_ERR_EN
    check("post_rst_err_cnt", err_cnt, 8'd0);
`endif
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("no_stale_%0d", k), out_valid, 5'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
